// File: rtl/sparse_weight_encoder.sv
// Sparse weight encoder: compresses a raster-ordered dense KxK kernel into
// packed nonzero values, row indices, column indices and a nonzero count.
// The result is held stable until the consumer acknowledges it.
module sparse_weight_encoder #(
    parameter int WORD_LENGTH = 8,
    parameter int KERNEL_SIZE = 5,
    parameter int MAX_NNZ     = 28,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic                           w_in_valid,
    input  logic [WORD_LENGTH-1:0]         w_in,
    output logic                           w_in_ready,
    output logic                           enc_valid,
    input  logic                           enc_ack,
    output logic [MAX_NNZ*WORD_LENGTH-1:0] value_packed,
    output logic [MAX_NNZ*WORD_LENGTH-1:0] rows_packed,
    output logic [MAX_NNZ*WORD_LENGTH-1:0] cols_packed,
    output logic [CNT_WIDTH-1:0]           valid_num,
    output logic                           overflow
);

    typedef enum logic {
        COLLECT = 1'b0,
        DONE    = 1'b1
    } state_e;

    localparam int                     PW      = MAX_NNZ * WORD_LENGTH;
    localparam logic [WORD_LENGTH-1:0] K_LAST  = WORD_LENGTH'(KERNEL_SIZE - 1);
    localparam logic [CNT_WIDTH-1:0]   CNT_MAX = CNT_WIDTH'(MAX_NNZ);

    state_e                 state_q, state_d;
    logic [WORD_LENGTH-1:0] row_q, row_d;
    logic [WORD_LENGTH-1:0] col_q, col_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]          value_q, value_d;
    logic [PW-1:0]          rows_q, rows_d;
    logic [PW-1:0]          cols_q, cols_d;
    logic                   overflow_q, overflow_d;
    logic                   accept;
    logic                   last_pos;

    assign accept   = w_in_valid && w_in_ready;
    assign last_pos = (row_q == K_LAST) && (col_q == K_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples its _d value from before the edge, independent of block order.
        if (rst) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: finish on the last raster position, return to COLLECT on ack or clear.
    always_comb begin
        // NOTE: defaulting state_d first means no path leaves it unassigned,
        // so no latch is inferred.
        state_d = state_q;
        if (clear) begin
            state_d = COLLECT;
        end else begin
            case (state_q)
                COLLECT: if (accept && last_pos) state_d = DONE;
                DONE:    if (enc_ack)            state_d = COLLECT;
                default:                         state_d = COLLECT;
            endcase
        end
    end

    // Handshake outputs decoded purely from the current state.
    always_comb begin
        w_in_ready = (state_q == COLLECT);
        enc_valid  = (state_q == DONE);
    end

    // Datapath next state: position counters, slot writes, count and overflow.
    always_comb begin
        row_d      = row_q;
        col_d      = col_q;
        cnt_d      = cnt_q;
        value_d    = value_q;
        rows_d     = rows_q;
        cols_d     = cols_q;
        overflow_d = overflow_q;
        if (clear || (enc_valid && enc_ack)) begin
            row_d      = '0;
            col_d      = '0;
            cnt_d      = '0;
            value_d    = '0;
            rows_d     = '0;
            cols_d     = '0;
            overflow_d = 1'b0;
        end else if (accept) begin
            if (col_q == K_LAST) begin
                col_d = '0;
                row_d = row_q + WORD_LENGTH'(1);
            end else begin
                col_d = col_q + WORD_LENGTH'(1);
            end
            if (w_in != '0) begin
                if (cnt_q < CNT_MAX) begin
                    for (int i = 0; i < MAX_NNZ; i++) begin
                        if (CNT_WIDTH'(i) == cnt_q) begin
                            value_d[WORD_LENGTH*i +: WORD_LENGTH] = w_in;
                            rows_d[WORD_LENGTH*i +: WORD_LENGTH]  = row_q;
                            cols_d[WORD_LENGTH*i +: WORD_LENGTH]  = col_q;
                        end
                    end
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the slot storage drives the outputs directly and must read as zero
        // after reset, so unlike a RAM array it is reset along with the counters.
        if (rst) begin
            row_q      <= '0;
            col_q      <= '0;
            cnt_q      <= '0;
            value_q    <= '0;
            rows_q     <= '0;
            cols_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            row_q      <= row_d;
            col_q      <= col_d;
            cnt_q      <= cnt_d;
            value_q    <= value_d;
            rows_q     <= rows_d;
            cols_q     <= cols_d;
            overflow_q <= overflow_d;
        end
    end

    assign value_packed = value_q;
    assign rows_packed  = rows_q;
    assign cols_packed  = cols_q;
    assign valid_num    = cnt_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_sparse_weight_encoder.sv
// Self-checking bench for sparse_weight_encoder: table-driven kernels from the
// test plan, hand sequences for backpressure/overflow/abort, and random kernels
// checked against a behavioural model. A second instance uses MAX_NNZ=4.
module tb_sparse_weight_encoder;

    localparam int KW = 200;   // 25 weights x 8 bits
    localparam int PW = 224;   // 28 slots x 8 bits

    typedef struct packed {
        logic [KW-1:0] kernel;
        logic [PW-1:0] value;
        logic [PW-1:0] rows;
        logic [PW-1:0] cols;
        logic [15:0]   num;
        logic          ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          w_in_valid;
    logic [7:0]    w_in;
    logic          enc_ack;

    logic          rdy0, ev0, ovf0;
    logic [PW-1:0] v0, r0, c0;
    logic [15:0]   num0;
    logic          rdy4, ev4, ovf4;
    logic [31:0]   v4, r4, c4;
    logic [15:0]   num4;

    int n_pass  = 0;
    int n_total = 0;

    exp_t tab [4];

    always #5 clk = ~clk;

    sparse_weight_encoder dut0 (
        .clk(clk), .rst(rst), .clear(clear),
        .w_in_valid(w_in_valid), .w_in(w_in), .w_in_ready(rdy0),
        .enc_valid(ev0), .enc_ack(enc_ack),
        .value_packed(v0), .rows_packed(r0), .cols_packed(c0),
        .valid_num(num0), .overflow(ovf0)
    );

    sparse_weight_encoder #(.MAX_NNZ(4)) dut4 (
        .clk(clk), .rst(rst), .clear(clear),
        .w_in_valid(w_in_valid), .w_in(w_in), .w_in_ready(rdy4),
        .enc_valid(ev4), .enc_ack(enc_ack),
        .value_packed(v4), .rows_packed(r4), .cols_packed(c4),
        .valid_num(num4), .overflow(ovf4)
    );

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // Reference: walk the kernel in raster order, keep the first max_nnz nonzeros.
    function automatic exp_t model(input logic [KW-1:0] k, input int max_nnz);
        exp_t       e;
        int         n;
        logic [7:0] w;
        e = '0;
        n = 0;
        e.kernel = k;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                w = k[8*(r*5+c) +: 8];
                if (w != 8'h00) begin
                    if (n < max_nnz) begin
                        e.value[8*n +: 8] = w;
                        e.rows[8*n +: 8]  = 8'(r);
                        e.cols[8*n +: 8]  = 8'(c);
                        n++;
                    end else begin
                        e.ovf = 1'b1;
                    end
                end
            end
        end
        e.num = 16'(n);
        return e;
    endfunction

    task automatic check_res(input string tag, input exp_t e, input logic [PW-1:0] av,
                             input logic [PW-1:0] ar, input logic [PW-1:0] ac,
                             input logic [15:0] an, input logic ao, input logic aev);
        check1({tag, "_enc_valid"}, aev, 1'b1);
        check({tag, "_value"}, av, e.value);
        check({tag, "_rows"}, ar, e.rows);
        check({tag, "_cols"}, ac, e.cols);
        check({tag, "_valid_num"}, PW'(an), PW'(e.num));
        check1({tag, "_overflow"}, ao, e.ovf);
    endtask

    task automatic check_both(input string tag, input exp_t e0);
        check_res({tag, "_d28"}, e0, v0, r0, c0, num0, ovf0, ev0);
        check_res({tag, "_d4"}, model(e0.kernel, 4), PW'(v4), PW'(r4), PW'(c4), num4, ovf4, ev4);
    endtask

    // Feed the first n_acc weights, with up to gap idle cycles before each and
    // optionally random enc_ack noise while collecting.
    task automatic feed(input logic [KW-1:0] k, input int n_acc, input int gap, input bit ack_noise);
        for (int i = 0; i < n_acc; i++) begin
            int idle = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
            repeat (idle) begin
                w_in_valid = 1'b0;
                w_in       = 8'($urandom);
                enc_ack    = ack_noise ? 1'($urandom) : 1'b0;
                @(posedge clk); #1;
            end
            check1("ready_collect", rdy0, 1'b1);
            if (i == 24) check1("enc_valid_before_last", ev0, 1'b0);
            w_in_valid = 1'b1;
            w_in       = k[8*i +: 8];
            enc_ack    = ack_noise ? 1'($urandom) : 1'b0;
            @(posedge clk); #1;
        end
        w_in_valid = 1'b0;
        enc_ack    = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check1({tag, "_enc_valid"}, ev0, 1'b0);
        check1({tag, "_ready"}, rdy0, 1'b1);
        check({tag, "_valid_num"}, PW'(num0), '0);
        check({tag, "_value"}, v0, '0);
        check({tag, "_rows"}, r0, '0);
        check({tag, "_cols"}, c0, '0);
        check1({tag, "_overflow"}, ovf0, 1'b0);
        check({tag, "_valid_num_d4"}, PW'(num4), '0);
        check1({tag, "_overflow_d4"}, ovf4, 1'b0);
    endtask

    task automatic do_ack(input string tag);
        enc_ack = 1'b1;
        @(posedge clk); #1;
        enc_ack = 1'b0;
        check_idle({tag, "_after_ack"});
    endtask

    initial begin
        logic [KW-1:0] k_full, k_sparse, k_ones, k;
        exp_t          e;

        k_full   = 200'h08_09_03_02_fd_05_09_09_08_01_ff_ff_03_07_06_f5_fc_fc_02_04_f9_f8_fd_ff_01;
        k_sparse = (KW'(8'h01) << 192) | (KW'(8'hfe) << 104) | KW'(8'h07);
        k_ones   = {25{8'h01}};

        tab[0] = '{kernel: k_full,
                   value: PW'(k_full),
                   rows: PW'(200'h04_04_04_04_04_03_03_03_03_03_02_02_02_02_02_01_01_01_01_01_00_00_00_00_00),
                   cols: PW'({5{40'h04_03_02_01_00}}),
                   num: 16'd25, ovf: 1'b0};
        tab[1] = '{kernel: k_sparse, value: PW'(24'h01_fe_07), rows: PW'(24'h04_02_00),
                   cols: PW'(24'h04_03_00), num: 16'd3, ovf: 1'b0};
        tab[2] = '{kernel: '0, value: '0, rows: '0, cols: '0, num: 16'd0, ovf: 1'b0};
        tab[3] = '{kernel: k_ones, value: PW'(k_ones), rows: tab[0].rows, cols: tab[0].cols,
                   num: 16'd25, ovf: 1'b0};

        rst = 1'b1; clear = 1'b0; w_in_valid = 1'b0; w_in = '0; enc_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_idle("reset");

        // Table-driven kernels, increasing idle gaps, ack noise while collecting.
        for (int i = 0; i < 4; i++) begin
            feed(tab[i].kernel, 25, i, 1'b1);
            check_both($sformatf("tab%0d", i), tab[i]);
            do_ack($sformatf("tab%0d", i));
        end

        // Overflow on the 4-slot instance, explicit expectations.
        feed(k_ones, 25, 0, 1'b0);
        check(  "ovf_value_d4", PW'(v4), PW'(32'h01_01_01_01));
        check(  "ovf_rows_d4", PW'(r4), '0);
        check(  "ovf_cols_d4", PW'(c4), PW'(32'h03_02_01_00));
        check(  "ovf_num_d4", PW'(num4), PW'(16'd4));
        check1( "ovf_flag_d4", ovf4, 1'b1);
        do_ack("ovf");

        // Backpressure: hold w_in_valid in DONE with no ack, outputs must not move.
        feed(k_full, 25, 3, 1'b0);
        for (int c = 0; c < 5; c++) begin
            w_in_valid = 1'b1;
            w_in       = 8'($urandom_range(255, 1));
            @(posedge clk); #1;
            check1("hold_ready", rdy0, 1'b0);
            check_both("hold", tab[0]);
        end
        w_in_valid = 1'b0;
        do_ack("hold");
        feed(k_sparse, 25, 0, 1'b0);
        check_both("post_hold", tab[1]);
        do_ack("post_hold");

        // clear after 10 accepts, with a same-cycle accept that must be dropped.
        feed(k_full, 10, 0, 1'b0);
        clear = 1'b1; w_in_valid = 1'b1; w_in = 8'h55;
        @(posedge clk); #1;
        clear = 1'b0; w_in_valid = 1'b0;
        check_idle("clear_mid");
        feed(k_sparse, 25, 0, 1'b0);
        check_both("after_clear", tab[1]);

        // clear in DONE beats a same-cycle ack.
        clear = 1'b1; enc_ack = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; enc_ack = 1'b0;
        check_idle("clear_done");

        // Asynchronous reset after 10 accepts.
        feed(k_full, 10, 0, 1'b0);
        rst = 1'b1;
        #1;
        check_idle("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        feed(k_full, 25, 0, 1'b0);
        check_both("after_rst", tab[0]);
        do_ack("after_rst");

        // Random kernels of varying density against the model.
        for (int t = 0; t < 12; t++) begin
            int dens = int'($urandom_range(100, 0));
            for (int j = 0; j < 25; j++)
                k[8*j +: 8] = (int'($urandom_range(99, 0)) < dens) ? 8'($urandom_range(255, 1)) : 8'h00;
            e = model(k, 28);
            feed(k, 25, 2, 1'b1);
            check_both($sformatf("rand%0d", t), e);
            do_ack($sformatf("rand%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
